// File: rtl/grf_scoreboard_pkg.sv
// Shared definitions for the GRF issue scoreboard: register index widths,
// the zero register and the default pending-write counter width.
package grf_scoreboard_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int DEF_CNT_W = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]  reg_mask_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

  // True when idx addresses register slot reg_num.
  function automatic logic reg_hit(input reg_idx_t idx, input int reg_num);
    return (idx == reg_idx_t'(reg_num));
  endfunction

endpackage

// File: rtl/sb_counter.sv
// One pending-write counter: saturating up/down count with a synchronous clear.
// An increment and a decrement in the same cycle cancel.
module sb_counter
  import grf_scoreboard_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_busy,
  output logic o_full
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_up;
  logic             w_dn;

  // Decrement at zero is dropped: write-backs of work issued before a flush.
  assign w_up = i_inc & ~i_dec & (r_cnt != CNT_MAX);
  assign w_dn = i_dec & ~i_inc & (r_cnt != '0);

  // NOTE: sequential state uses non-blocking assignments so every counter
  // samples the same pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (w_up) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_dn) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_full = (r_cnt == CNT_MAX);

endmodule

// File: rtl/grf_scoreboard.sv
// Issue-side scoreboard for the 32-entry GRF: counts in-flight writes per
// register and stalls issue on a read hazard or a saturated counter.
module grf_scoreboard
  import grf_scoreboard_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rs,
  input  logic [4:0]      i_issue_rt,
  input  logic            i_use_rs,
  input  logic            i_use_rt,
  input  logic            i_issue_reg_write,
  input  logic [4:0]      i_issue_a3,
  input  logic            i_wb_reg_write,
  input  logic [4:0]      i_wb_a3,
  input  logic            i_flush,
  output logic            o_stall,
  output logic [31:0]     o_busy_mask
);

  reg_mask_t             w_busy;
  reg_mask_t             w_full;
  logic [NUM_REGS-1:1]   w_inc;
  logic [NUM_REGS-1:1]   w_dec;
  logic                  w_hazard;
  logic                  w_full_hit;
  logic                  w_stall;
  logic                  w_accept;

  // Register 0 has no counter, so it can never be busy or full.
  assign w_busy[0] = 1'b0;
  assign w_full[0] = 1'b0;

  // No same-cycle bypass: hazards look only at the current counters.
  assign w_hazard   = (i_use_rs & w_busy[i_issue_rs]) |
                      (i_use_rt & w_busy[i_issue_rt]);
  assign w_full_hit = i_issue_reg_write & (i_issue_a3 != ZERO_REG) &
                      w_full[i_issue_a3];
  assign w_stall    = i_issue_valid & (w_hazard | w_full_hit) & ~i_reset;
  assign w_accept   = i_issue_valid & ~w_stall & ~i_flush & ~i_reset;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_inc[i] = w_accept & i_issue_reg_write & reg_hit(i_issue_a3, i);
      w_dec[i] = i_wb_reg_write & reg_hit(i_wb_a3, i);
    end
  end

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (i_flush),
      .i_inc   (w_inc[g]),
      .i_dec   (w_dec[g]),
      .o_busy  (w_busy[g]),
      .o_full  (w_full[g])
    );
  end

  assign o_stall     = w_stall;
  assign o_busy_mask = w_busy;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: each driven cycle queues its expected
// Stall/BusyMask, and a negedge monitor pops and compares.
module tb_grf_scoreboard;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        use_rs;
  logic        use_rt;
  logic        issue_reg_write;
  logic [4:0]  issue_a3;
  logic        wb_reg_write;
  logic [4:0]  wb_a3;
  logic        flush;
  logic        stall;
  logic [31:0] busy_mask;

  typedef struct {
    string       name;
    logic        stall;
    logic [31:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  grf_scoreboard #(.CNT_W(2)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_issue_valid     (issue_valid),
    .i_issue_rs        (issue_rs),
    .i_issue_rt        (issue_rt),
    .i_use_rs          (use_rs),
    .i_use_rt          (use_rt),
    .i_issue_reg_write (issue_reg_write),
    .i_issue_a3        (issue_a3),
    .i_wb_reg_write    (wb_reg_write),
    .i_wb_a3           (wb_a3),
    .i_flush           (flush),
    .o_stall           (stall),
    .o_busy_mask       (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each driven cycle is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, "_stall"}, {31'd0, stall}, {31'd0, e.stall});
      check({e.name, "_mask"}, busy_mask, e.mask);
    end
  end

  // Drive one cycle of inputs; optionally queue the expected outputs.
  task automatic step(input string name, input logic rst, input logic fl,
                      input logic vld, input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt,
                      input logic rw, input logic [4:0] a3,
                      input logic wb, input logic [4:0] wa3,
                      input logic chk, input logic es, input logic [31:0] em);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    flush           = fl;
    issue_valid     = vld;
    issue_rs        = rs;
    use_rs          = urs;
    issue_rt        = rt;
    use_rt          = urt;
    issue_reg_write = rw;
    issue_a3        = a3;
    wb_reg_write    = wb;
    wb_a3           = wa3;
    if (chk) begin
      e.name  = name;
      e.stall = es;
      e.mask  = em;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0;
    issue_rs = '0; issue_rt = '0; use_rs = 1'b0; use_rt = 1'b0;
    issue_reg_write = 1'b0; issue_a3 = '0; wb_reg_write = 1'b0; wb_a3 = '0;

    //    name          rst fl  vld rs  urs rt  urt rw  a3  wb  wa3 chk st  mask
    step("init_rst",    1,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  32'h0);
    step("rst_read89",  0,  0,  1,  8,  1,  9,  1,  0,  0,  0,  0,  1,  0,  32'h0);
    step("wr8",         0,  0,  1,  0,  0,  0,  0,  1,  8,  0,  0,  1,  0,  32'h0);
    step("rd8_haz",     0,  0,  1,  8,  1,  0,  0,  0,  0,  0,  0,  1,  1,  32'h100);
    step("rd8_wb_same", 0,  0,  1,  8,  1,  0,  0,  0,  0,  1,  8,  1,  1,  32'h100);
    step("rd8_after_wb",0,  0,  1,  8,  1,  0,  0,  0,  0,  0,  0,  1,  0,  32'h0);
    // Fill $5 to saturation, then exercise concurrent inc/dec.
    step("wr5_a",       0,  0,  1,  0,  0,  0,  0,  1,  5,  0,  0,  1,  0,  32'h0);
    step("wr5_b",       0,  0,  1,  0,  0,  0,  0,  1,  5,  0,  0,  1,  0,  32'h20);
    step("wr5_c",       0,  0,  1,  0,  0,  0,  0,  1,  5,  0,  0,  1,  0,  32'h20);
    step("wr5_full",    0,  0,  1,  0,  0,  0,  0,  1,  5,  0,  0,  1,  1,  32'h20);
    step("wb5_to2",     0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  5,  1,  0,  32'h20);
    step("wr5_wb5",     0,  0,  1,  0,  0,  0,  0,  1,  5,  1,  5,  1,  0,  32'h20);
    step("wr5_to3",     0,  0,  1,  0,  0,  0,  0,  1,  5,  0,  0,  1,  0,  32'h20);
    step("wr5_full2",   0,  0,  1,  0,  0,  0,  0,  1,  5,  0,  0,  1,  1,  32'h20);
    step("wb5_d1",      0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  5,  1,  0,  32'h20);
    step("wb5_d2",      0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  5,  1,  0,  32'h20);
    step("wb5_d3",      0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  5,  1,  0,  32'h20);
    // Register 0 never becomes pending.
    step("wr0",         0,  0,  1,  0,  0,  0,  0,  1,  0,  0,  0,  1,  0,  32'h0);
    step("rd0_wb0",     0,  0,  1,  0,  1,  0,  1,  0,  0,  1,  0,  1,  0,  32'h0);
    // Flush clears pending $3/$4; later write-back to $3 must not underflow.
    step("wr3",         0,  0,  1,  0,  0,  0,  0,  1,  3,  0,  0,  1,  0,  32'h0);
    step("wr4",         0,  0,  1,  0,  0,  0,  0,  1,  4,  0,  0,  1,  0,  32'h8);
    step("flush_rd3",   0,  1,  1,  3,  1,  0,  0,  0,  0,  1,  4,  1,  1,  32'h18);
    step("wb3_rd3",     0,  0,  1,  3,  1,  0,  0,  0,  0,  1,  3,  1,  0,  32'h0);
    step("rd3_rd4",     0,  0,  1,  3,  1,  4,  1,  0,  0,  0,  0,  1,  0,  32'h0);
    // Reset mid-operation with $7 pending.
    step("wr7",         0,  0,  1,  0,  0,  0,  0,  1,  7,  0,  0,  1,  0,  32'h0);
    step("rst_rd7",     1,  0,  1,  7,  1,  0,  0,  0,  0,  0,  0,  1,  0,  32'h80);
    step("rd7_wb7",     0,  0,  1,  7,  1,  0,  0,  0,  0,  1,  7,  1,  0,  32'h0);
    step("rd7",         0,  0,  1,  7,  1,  0,  0,  0,  0,  0,  0,  1,  0,  32'h0);
    // Reading own destination, use flags and valid gating.
    step("rd9_wr9",     0,  0,  1,  9,  1,  0,  0,  1,  9,  0,  0,  1,  0,  32'h0);
    step("rt9_haz",     0,  0,  1,  0,  0,  9,  1,  0,  0,  0,  0,  1,  1,  32'h200);
    step("rs9_unused",  0,  0,  1,  9,  0,  9,  0,  0,  0,  0,  0,  1,  0,  32'h200);
    step("novalid_wb9", 0,  0,  0,  9,  1,  0,  0,  0,  0,  1,  9,  1,  0,  32'h200);
    step("idle_end",    0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
